clock_period_meter: RTL and testbench
=====================================

CLOCK_PERIOD_METER -- requirements
Module: clock_period_meter

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth on meas_clk (legal range 2..4).
REQ-002 The block SHALL have parameter CNT_W, default 32, giving the width of every cycle counter and result.
REQ-003 The block SHALL have port clk, input, 1 bit: system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port meas_clk, input, 1 bit: asynchronous slow clock under measurement (e.g. a divided clock).
REQ-006 The block SHALL have port enable, input, 1 bit: measurement enable.
REQ-007 The block SHALL have port n_periods, input, 8 bits: number of meas_clk periods accumulated per result; 0 is treated as 1.
REQ-008 The block SHALL have port timeout, input, CNT_W bits: maximum clk cycles without a detected rising edge; 0 disables the timeout.
REQ-009 The block SHALL have port period_sum, output, CNT_W bits: clk cycles spanned by the last n_periods periods.
REQ-010 The block SHALL have port high_sum, output, CNT_W bits: clk cycles with synchronized meas_clk high within the same window.
REQ-011 The block SHALL have port valid, output, 1 bit: single-cycle pulse when period_sum and high_sum update.
REQ-012 The block SHALL have port overflow, output, 1 bit: the last result saturated; updated together with valid.
REQ-013 The block SHALL have port timeout_err, output, 1 bit: sticky timeout flag.
REQ-014 The block SHALL have port busy, output, 1 bit: high in states ARM and MEASURE.

Function
REQ-015 meas_clk SHALL pass through a SYNC_STAGES flip-flop synchronizer and then a 1-cycle rising-edge detector, so detection occurs SYNC_STAGES+1 clk cycles after the meas_clk edge.
REQ-016 The FSM SHALL have states IDLE, ARM and MEASURE; it is in IDLE whenever enable=0, and it moves IDLE->ARM on the first cycle with enable=1.
REQ-017 On entry to ARM, n_periods SHALL be latched (0 latched as 1); changes to n_periods are ignored until the next ARM entry.
REQ-018 In ARM, the first detected rising edge SHALL cause a transition to MEASURE with cycle_cnt=1, high_cnt=0 and edge_cnt=0.
REQ-019 In MEASURE, cycle_cnt SHALL increment every cycle, and high_cnt SHALL increment on each cycle where the synchronized level is 1.
REQ-020 In MEASURE, each detected rising edge SHALL increment edge_cnt; on the edge where edge_cnt+1 equals the latched n_periods, the block SHALL, in that same cycle, load period_sum=cycle_cnt, high_sum=high_cnt and overflow=sat flag, and pulse valid.
REQ-021 In that same cycle it SHALL restart the window with cycle_cnt=1, high_cnt=0 and edge_cnt=0, and stay in MEASURE (continuous back-to-back results, no gap).
REQ-022 cycle_cnt and high_cnt SHALL saturate at all-ones rather than wrap; the sat flag is set on saturation and cleared on window restart.
REQ-023 In ARM or MEASURE with timeout!=0, when cycles since the last detected edge (or since ARM entry) reach timeout, the block SHALL set timeout_err, move to ARM, and produce no valid.
REQ-024 timeout_err SHALL stay set until enable=0 or reset; measurement resumes on the next edge.
REQ-025 Deasserting enable mid-window SHALL move to IDLE the next cycle, discard the partial window and emit no valid; period_sum, high_sum and overflow SHALL hold their last values.
REQ-026 If a detected edge and timeout expiry coincide, the edge SHALL win and the timeout counter SHALL restart.

Reset
REQ-027 While rst_n=0, the block SHALL set state=IDLE; period_sum, high_sum, valid, overflow, timeout_err and busy SHALL be 0; and all counters and synchronizer stages SHALL be 0.
REQ-028 Reset SHALL take priority over enable and over every in-progress window.

Structure
REQ-029 The shared package SHALL hold the FSM state enum (IDLE/ARM/MEASURE), the CNT_W default, and the saturation all-ones constant helper.
REQ-030 The synchronizer plus rising-edge detector SHALL be one sub-module named edge_sync, parameterized by SYNC_STAGES, with outputs level and rise.
REQ-031 The rest of the block (FSM, counters, output registers) SHALL be in clock_period_meter.

Verification
REQ-032 Divider at N=5, DIVIDE=1 driving meas_clk, n_periods=4, enable=1 -> after the first window, valid every 40 cycles with period_sum=40 and high_sum=20, repeated.
REQ-033 n_periods=0 with meas_clk period 10 -> valid every 10 cycles with period_sum=10.
REQ-034 timeout=100, meas_clk held low after arming -> timeout_err=1 exactly 100 cycles after ARM entry, no valid; clock restored -> valid resumes and timeout_err stays 1 until enable=0.
REQ-035 CNT_W=8, meas_clk period 300, n_periods=1 -> period_sum=255 and overflow=1; next window with period 10 -> overflow=0.
REQ-036 enable dropped after 2 of 4 periods, then raised again -> no valid in the aborted window; the first new result is a full, correct 4-period sum.
REQ-037 rst_n pulsed low for 1 cycle mid-window -> all outputs 0 the next cycle; the FSM re-arms and the first valid appears after a full window.

Source files
------------

// File: rtl/clock_period_meter_pkg.sv
// ---------------------------------------------------------------------------
// clock_period_meter_pkg
// Shared definitions for the clock period meter:
//   state_t    - measurement FSM states (IDLE / ARM / MEASURE)
//   CNT_W_DEF  - default width of the cycle counters and results
//   sat_max()  - all-ones value for a counter of a given width (saturation cap)
// ---------------------------------------------------------------------------
package clock_period_meter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      MEASURE = 2'd2
   } state_t;

   localparam int CNT_W_DEF = 32;

   // All-ones of width w (w up to 64), returned right-aligned in 64 bits.
   function automatic logic [63:0] sat_max(input int unsigned w);
      if (w >= 64) sat_max = '1;
      else         sat_max = (64'd1 << w) - 64'd1;
   endfunction

endpackage

// File: rtl/clock_period_meter_edge_sync.sv
// ---------------------------------------------------------------------------
// edge_sync
// Brings the asynchronous meas_clk into the clk domain through a
// SYNC_STAGES-deep flop chain and detects its rising edge.
//   clk, rst_n  - system clock / synchronous active-low reset
//   meas_clk    - asynchronous input
//   level       - synchronized level, delayed one cycle behind rise
//   rise        - one-cycle pulse on a synchronized 0->1 transition
// rise is visible in the cycle after the last sync stage goes high, so the
// consumer registers it SYNC_STAGES+1 clk edges after the meas_clk edge.
// level lags rise by one cycle, which makes a window that opens and closes
// on rise count exactly the high cycles of each full meas_clk period.
// ---------------------------------------------------------------------------
module edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic meas_clk,
   output logic level,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   lvl_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q <= '0;
         lvl_q  <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], meas_clk};
         lvl_q  <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level = lvl_q;
   assign rise  = sync_q[SYNC_STAGES-1] & ~lvl_q;

endmodule

// File: rtl/clock_period_meter.sv
// ---------------------------------------------------------------------------
// clock_period_meter
// Measures how many clk cycles a window of n_periods meas_clk periods spans,
// and how many of those cycles meas_clk was high. Results are produced
// back-to-back, one per window, with saturation and an edge-loss timeout.
//   clk, rst_n   - system clock / synchronous active-low reset
//   meas_clk     - asynchronous clock under measurement
//   enable       - run measurement; low forces IDLE and clears timeout_err
//   n_periods    - periods per window (0 behaves as 1), latched on arming
//   timeout      - max clk cycles without an edge (0 = no timeout)
//   period_sum   - clk cycles in the last window
//   high_sum     - clk cycles with meas_clk high in the last window
//   valid        - one-cycle pulse when the sums update
//   overflow     - last window saturated a counter
//   timeout_err  - sticky edge-loss flag
//   busy         - FSM in ARM or MEASURE
// ---------------------------------------------------------------------------
module clock_period_meter
   import clock_period_meter_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             meas_clk,
   input  logic             enable,
   input  logic [7:0]       n_periods,
   input  logic [CNT_W-1:0] timeout,
   output logic [CNT_W-1:0] period_sum,
   output logic [CNT_W-1:0] high_sum,
   output logic             valid,
   output logic             overflow,
   output logic             timeout_err,
   output logic             busy
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic level, rise;

   edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .meas_clk (meas_clk),
      .level    (level),
      .rise     (rise)
   );

   state_t           state;
   logic [7:0]       n_lat;
   logic [7:0]       edge_cnt;
   logic [CNT_W-1:0] cycle_cnt, high_cnt, to_cnt;
   logic             sat;

   // Saturating next values and window/timeout decisions.
   logic [CNT_W-1:0] cycle_inc, high_inc, to_inc;
   logic             cycle_sat, high_sat, to_hit, last_edge;

   always_comb begin
      cycle_sat = (cycle_cnt == CNT_MAX);
      cycle_inc = cycle_sat ? CNT_MAX : cycle_cnt + CNT_ONE;
      high_sat  = level && (high_cnt == CNT_MAX);
      high_inc  = high_cnt;
      if (level && !high_sat) high_inc = high_cnt + CNT_ONE;
      to_inc    = (to_cnt == CNT_MAX) ? CNT_MAX : to_cnt + CNT_ONE;
      // to_cnt holds cycles since the last edge; expire when this cycle makes it timeout
      to_hit    = (timeout != '0) && (to_inc == timeout);
      last_edge = ((edge_cnt + 8'd1) == n_lat);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         n_lat       <= 8'd1;
         edge_cnt    <= '0;
         cycle_cnt   <= '0;
         high_cnt    <= '0;
         to_cnt      <= '0;
         sat         <= 1'b0;
         period_sum  <= '0;
         high_sum    <= '0;
         valid       <= 1'b0;
         overflow    <= 1'b0;
         timeout_err <= 1'b0;
         busy        <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (!enable) begin
            // partial window is simply abandoned; result registers hold
            state       <= IDLE;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  state  <= ARM;
                  busy   <= 1'b1;
                  n_lat  <= (n_periods == 8'd0) ? 8'd1 : n_periods;
                  to_cnt <= '0;
               end
               ARM: begin
                  if (rise) begin
                     state     <= MEASURE;
                     cycle_cnt <= CNT_ONE;
                     high_cnt  <= '0;
                     edge_cnt  <= '0;
                     sat       <= 1'b0;
                     to_cnt    <= '0;
                  end else if (to_hit) begin
                     timeout_err <= 1'b1;
                     to_cnt      <= '0;
                  end else begin
                     to_cnt <= to_inc;
                  end
               end
               MEASURE: begin
                  if (rise) begin
                     // an edge always beats a coincident timeout
                     to_cnt <= '0;
                     if (last_edge) begin
                        period_sum <= cycle_cnt;
                        high_sum   <= high_cnt;
                        overflow   <= sat;
                        valid      <= 1'b1;
                        cycle_cnt  <= CNT_ONE;
                        high_cnt   <= '0;
                        edge_cnt   <= '0;
                        sat        <= 1'b0;
                     end else begin
                        edge_cnt  <= edge_cnt + 8'd1;
                        cycle_cnt <= cycle_inc;
                        high_cnt  <= high_inc;
                        sat       <= sat | cycle_sat | high_sat;
                     end
                  end else if (to_hit) begin
                     timeout_err <= 1'b1;
                     state       <= ARM;
                     to_cnt      <= '0;
                  end else begin
                     to_cnt    <= to_inc;
                     cycle_cnt <= cycle_inc;
                     high_cnt  <= high_inc;
                     sat       <= sat | cycle_sat | high_sat;
                  end
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_clock_period_meter.sv
// ---------------------------------------------------------------------------
// tb_clock_period_meter
// Directed scoreboard bench. Stimulus pushes the hand-computed result of each
// expected window into a queue; a monitor pops and compares on every valid.
// A second instance with CNT_W=8 covers counter saturation.
// ---------------------------------------------------------------------------
module tb_clock_period_meter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        meas_clk = 1'b0;
   logic        enable = 1'b0;
   logic        en8 = 1'b0;
   logic [7:0]  n_periods = 8'd4;
   logic [31:0] timeout = '0;

   logic [31:0] period_sum, high_sum;
   logic        valid, overflow, timeout_err, busy;
   logic [7:0]  p8, h8;
   logic        v8, o8, t8, b8;

   always #5 clk = ~clk;

   clock_period_meter #(.SYNC_STAGES(2), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .meas_clk(meas_clk), .enable(enable),
      .n_periods(n_periods), .timeout(timeout),
      .period_sum(period_sum), .high_sum(high_sum), .valid(valid),
      .overflow(overflow), .timeout_err(timeout_err), .busy(busy)
   );

   clock_period_meter #(.SYNC_STAGES(2), .CNT_W(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .meas_clk(meas_clk), .enable(en8),
      .n_periods(n_periods), .timeout(8'd0),
      .period_sum(p8), .high_sum(h8), .valid(v8),
      .overflow(o8), .timeout_err(t8), .busy(b8)
   );

   typedef struct {
      logic [31:0] p;
      logic [31:0] h;
      logic        ov;
   } exp_t;

   exp_t q[$];
   exp_t q8[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // meas_clk generator: high for hi_c clk cycles, low for lo_c, stepped
   // just after each clk edge (a divider output).
   int hi_c = 5, lo_c = 5, ph = 0;
   bit meas_run = 1'b1;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (!meas_run) meas_clk = 1'b0;
         else begin
            ph = ph + 1;
            if (ph >= hi_c + lo_c) ph = 0;
            meas_clk = (ph < hi_c);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // monitor / scoreboard
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (valid) begin
            if (q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL unexpected_valid: got period_sum=%0d high_sum=%0d, expected no valid",
                        period_sum, high_sum);
            end else begin
               e = q.pop_front();
               chk("period_sum", period_sum, e.p);
               chk("high_sum", high_sum, e.h);
               chk("overflow", {31'd0, overflow}, {31'd0, e.ov});
            end
         end
         if (v8) begin
            if (q8.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL unexpected_valid8: got period_sum=%0d, expected no valid", p8);
            end else begin
               e = q8.pop_front();
               chk("period_sum8", {24'd0, p8}, e.p);
               chk("high_sum8", {24'd0, h8}, e.h);
               chk("overflow8", {31'd0, o8}, {31'd0, e.ov});
            end
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input int n, input int p, input int h, input bit ov);
      exp_t e;
      e.p = p; e.h = h; e.ov = ov;
      repeat (n) q.push_back(e);
   endtask

   task automatic push8(input int p, input int h, input bit ov);
      exp_t e;
      e.p = p; e.h = h; e.ov = ov;
      q8.push_back(e);
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget && (q.size() != 0 || q8.size() != 0); i++) @(negedge clk);
      if (q.size() != 0 || q8.size() != 0) begin
         n_tests++; n_fail++;
         $display("FAIL drain_timeout: got %0d results pending, expected 0", q.size() + q8.size());
         q.delete();
         q8.delete();
      end
   endtask

   // restart the generator so the next rise lands on a period boundary
   task automatic set_meas(input int h, input int l);
      hi_c = h; lo_c = l; ph = h + l - 1;
   endtask

   task automatic go_idle();
      enable = 1'b0;
      cycles(4);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running, expected finish");
      $fatal(1);
   end

   initial begin
      // ---- reset state
      cycles(3);
      chk("rst_period_sum", period_sum, 0);
      chk("rst_high_sum", high_sum, 0);
      chk("rst_valid", {31'd0, valid}, 0);
      chk("rst_overflow", {31'd0, overflow}, 0);
      chk("rst_timeout_err", {31'd0, timeout_err}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      rst_n = 1'b1;
      cycles(2);

      // ---- 50% duty, period 10, 4 periods per window; n_periods change ignored
      set_meas(5, 5); n_periods = 8'd4; cycles(4);
      push(3, 40, 20, 0);
      enable = 1'b1;
      cycles(20);
      chk("busy_running", {31'd0, busy}, 1);
      n_periods = 8'd1;
      drain(300);
      go_idle();
      chk("busy_idle", {31'd0, busy}, 0);

      // ---- n_periods = 0 acts as 1
      n_periods = 8'd0;
      push(3, 10, 5, 0);
      enable = 1'b1;
      drain(200);
      go_idle();

      // ---- asymmetric duty 3/12, 2 periods
      set_meas(3, 9); n_periods = 8'd2; cycles(4);
      push(2, 24, 6, 0);
      enable = 1'b1;
      drain(200);
      go_idle();

      // ---- timeout with meas_clk stuck low, then recovery
      set_meas(5, 5); n_periods = 8'd4; timeout = 32'd100;
      meas_run = 1'b0; cycles(4);
      enable = 1'b1;
      @(negedge clk);
      chk("busy_arm", {31'd0, busy}, 1);
      cycles(99);
      chk("timeout_before", {31'd0, timeout_err}, 0);
      cycles(1);
      chk("timeout_at_100", {31'd0, timeout_err}, 1);
      set_meas(5, 5); meas_run = 1'b1;
      push(2, 40, 20, 0);
      drain(300);
      chk("timeout_sticky", {31'd0, timeout_err}, 1);
      enable = 1'b0;
      @(negedge clk);
      chk("timeout_clear", {31'd0, timeout_err}, 0);
      timeout = '0;
      cycles(3);

      // ---- enable dropped mid-window: no result, last values held
      enable = 1'b1;
      cycles(35);
      enable = 1'b0;
      cycles(5);
      chk("hold_period_sum", period_sum, 40);
      chk("hold_high_sum", high_sum, 20);
      push(1, 40, 20, 0);
      enable = 1'b1;
      drain(200);
      go_idle();

      // ---- reset pulse mid-window (taken while meas_clk is settled low)
      enable = 1'b1;
      push(1, 40, 20, 0);
      drain(200);
      cycles(8);
      for (int i = 0; i < 20 && ph != hi_c + 3; i++) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("rstmid_period_sum", period_sum, 0);
      chk("rstmid_high_sum", high_sum, 0);
      chk("rstmid_overflow", {31'd0, overflow}, 0);
      chk("rstmid_valid", {31'd0, valid}, 0);
      chk("rstmid_busy", {31'd0, busy}, 0);
      push(1, 40, 20, 0);
      drain(200);
      go_idle();

      // ---- 8-bit instance: saturation then a clean window
      set_meas(150, 150); n_periods = 8'd1; cycles(4);
      push8(255, 150, 1);
      en8 = 1'b1;
      drain(1200);
      en8 = 1'b0;
      cycles(4);
      chk("hold_overflow8", {31'd0, o8}, 1);
      set_meas(5, 5); cycles(4);
      push8(10, 5, 0);
      en8 = 1'b1;
      drain(200);
      en8 = 1'b0;
      cycles(4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
